// File: rtl/rc4_pkg.sv
// Shared types, constants and helpers for the RC4 PRGA decrypt block.
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        GET_I,
        RD_J,
        WT_J,
        GET_J,
        WR_I,
        WR_J,
        RD_F,
        WT_F,
        GET_F,
        WR_D,
        DONE
    } prga_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LO    = 8'h61;
    localparam logic [7:0] ASCII_HI    = 8'h7A;

    // Plaintext is acceptable if it is a space or a lowercase letter.
    function automatic logic is_valid_char(input logic [7:0] c);
        return (c == ASCII_SPACE) || ((c >= ASCII_LO) && (c <= ASCII_HI));
    endfunction

endpackage

// File: rtl/prga_decrypt_if.sv
// Control handshake plus S RAM, encrypted ROM and decrypted RAM ports of
// the PRGA decrypt engine. master = engine side, slave = memories/controller.
interface prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              fail;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [MSG_AW-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;

    modport master (
        input  start, s_q, rom_q,
        output busy, done, fail,
        output s_address, s_data, s_wren,
        output rom_address,
        output dec_address, dec_data, dec_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  busy, done, fail,
        input  s_address, s_data, s_wren,
        input  rom_address,
        input  dec_address, dec_data, dec_wren
    );
endinterface

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation phase: walks the scheduled S array, swaps
// entries, XORs the keystream with the encrypted ROM and writes plaintext.
// Optional macro PRGA_ASCII_CHECK_EN: abort with fail=1 on the first
// plaintext byte that is not a space or lowercase letter.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    prga_decrypt_if.master bus
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    prga_state_t       state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        enc_q, enc_d;
    logic [7:0]        f_q, f_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic              fail_q, fail_d;

    logic [7:0]        plain;
    logic              char_ok;

    assign plain = f_q ^ enc_q;

`ifdef PRGA_ASCII_CHECK_EN
    assign char_ok  = is_valid_char(plain);
    assign bus.fail = fail_q;
`else
    assign char_ok  = 1'b1;
    assign bus.fail = 1'b0;
`endif

    assign bus.busy = (state_q != IDLE) && (state_q != DONE);
    assign bus.done = (state_q == DONE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            enc_q   <= '0;
            f_q     <= '0;
            k_q     <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            enc_q   <= enc_d;
            f_q     <= f_d;
            k_q     <= k_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state and datapath updates; each read waits two cycles for data.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        enc_d   = enc_q;
        f_d     = f_q;
        k_d     = k_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    fail_d  = 1'b0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                i_d     = i_q + 8'd1;
                state_d = WT_I;
            end
            WT_I:  state_d = GET_I;
            GET_I: begin
                si_d    = bus.s_q;
                enc_d   = bus.rom_q;
                j_d     = j_q + bus.s_q;
                state_d = RD_J;
            end
            RD_J:  state_d = WT_J;
            WT_J:  state_d = GET_J;
            GET_J: begin
                sj_d    = bus.s_q;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = RD_F;
            RD_F:  state_d = WT_F;
            WT_F:  state_d = GET_F;
            GET_F: begin
                f_d     = bus.s_q;
                state_d = WR_D;
            end
            WR_D: begin
                if (!char_ok) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = RD_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port decode from state and registers only; addresses are held
    // through the wait and capture cycles of every read.
    always_comb begin
        bus.s_address   = '0;
        bus.s_data      = '0;
        bus.s_wren      = 1'b0;
        bus.rom_address = '0;
        bus.dec_address = '0;
        bus.dec_data    = '0;
        bus.dec_wren    = 1'b0;
        case (state_q)
            RD_I: begin
                bus.s_address   = i_q + 8'd1;
                bus.rom_address = k_q;
            end
            WT_I, GET_I: begin
                bus.s_address   = i_q;
                bus.rom_address = k_q;
            end
            RD_J, WT_J, GET_J: bus.s_address = j_q;
            WR_I: begin
                bus.s_address = i_q;
                bus.s_data    = sj_q;
                bus.s_wren    = 1'b1;
            end
            WR_J: begin
                bus.s_address = j_q;
                bus.s_data    = si_q;
                bus.s_wren    = 1'b1;
            end
            RD_F, WT_F, GET_F: bus.s_address = si_q + sj_q;
            WR_D: begin
                bus.dec_address = k_q;
                bus.dec_data    = plain;
                bus.dec_wren    = char_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed bench for prga_decrypt: a 3-byte instance for the detailed
// scenarios and a 256-byte instance for the wrap/full-length scenario.
module tb_prga_decrypt;
    import rc4_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    prga_decrypt_if #(.MSG_AW(2)) bus_a ();
    prga_decrypt_if #(.MSG_AW(8)) bus_b ();

    prga_decrypt #(.MSG_LEN(3), .MSG_AW(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    prga_decrypt #(.MSG_LEN(256), .MSG_AW(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    // Memory models for instance A
    logic [7:0] s_mem_a [256];
    logic [7:0] rom_a   [4];
    logic [7:0] dec_a   [4];
    int         dec_cnt_a;
    logic       s_init_a = 1'b0;
    logic       dec_clr_a = 1'b0;

    always @(posedge clk) begin
        if (s_init_a) begin
            for (int n = 0; n < 256; n++) s_mem_a[n] <= 8'(n);
        end else if (bus_a.s_wren) begin
            s_mem_a[bus_a.s_address] <= bus_a.s_data;
        end
        bus_a.s_q   <= s_mem_a[bus_a.s_address];
        bus_a.rom_q <= rom_a[bus_a.rom_address];
        if (dec_clr_a) begin
            for (int n = 0; n < 4; n++) dec_a[n] <= 8'hEE;
            dec_cnt_a <= 0;
        end else if (bus_a.dec_wren) begin
            dec_a[bus_a.dec_address] <= bus_a.dec_data;
            dec_cnt_a <= dec_cnt_a + 1;
        end
    end

    // Memory models for instance B
    logic [7:0] s_mem_b [256];
    logic [7:0] rom_b   [256];
    logic [7:0] dec_b   [256];
    int         dec_cnt_b;
    logic [7:0] dec_last_b;
    int         swr_cnt_b;
    logic [7:0] swr0_b, swr1_b;
    logic       s_init_b = 1'b0;

    always @(posedge clk) begin
        if (s_init_b) begin
            for (int n = 0; n < 256; n++)
                s_mem_b[n] <= (n == 1) ? 8'hFF : (n == 255) ? 8'h01 : 8'(n);
            for (int n = 0; n < 256; n++) dec_b[n] <= 8'hEE;
            dec_cnt_b <= 0;
            swr_cnt_b <= 0;
        end else begin
            if (bus_b.s_wren) begin
                s_mem_b[bus_b.s_address] <= bus_b.s_data;
                if (swr_cnt_b == 0) swr0_b <= bus_b.s_address;
                if (swr_cnt_b == 1) swr1_b <= bus_b.s_address;
                swr_cnt_b <= swr_cnt_b + 1;
            end
            if (bus_b.dec_wren) begin
                dec_b[bus_b.dec_address] <= bus_b.dec_data;
                dec_last_b <= bus_b.dec_address;
                dec_cnt_b <= dec_cnt_b + 1;
            end
        end
        bus_b.s_q   <= s_mem_b[bus_b.s_address];
        bus_b.rom_q <= rom_b[bus_b.rom_address];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Identity S, fresh dec RAM (0xEE) and the given ROM bytes for instance A.
    task automatic load_a(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        @(negedge clk);
        rom_a[0] = r0;
        rom_a[1] = r1;
        rom_a[2] = r2;
        rom_a[3] = 8'h00;
        s_init_a = 1'b1;
        dec_clr_a = 1'b1;
        @(negedge clk);
        s_init_a = 1'b0;
        dec_clr_a = 1'b0;
    endtask

    // Pulse start and count edges (the accepting edge is 1) until done.
    task automatic run_a(input bit spam, output int cycles, output logic done1, output logic busy1);
        cycles = 0;
        done1 = 1'b1;
        busy1 = 1'b0;
        @(negedge clk);
        bus_a.start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            cycles++;
            bus_a.start = spam && (cycles % 4 == 2);
            if (cycles == 1) begin
                done1 = bus_a.done;
                busy1 = bus_a.busy;
            end
            if (bus_a.done) break;
        end
        bus_a.start = 1'b0;
    endtask

    task automatic check_dec_a(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        check_eq({tag, "_dec0"}, {24'h0, dec_a[0]}, {24'h0, e0});
        check_eq({tag, "_dec1"}, {24'h0, dec_a[1]}, {24'h0, e1});
        check_eq({tag, "_dec2"}, {24'h0, dec_a[2]}, {24'h0, e2});
    endtask

    initial begin
        int         cyc;
        logic       d1, b1;
        bit         seen;
        logic [7:0] ms [256];
        logic [7:0] mi, mj, tmp;
        int         bad;

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'h0, bus_a.busy}, 32'h0);
        check_eq("rst_done", {31'h0, bus_a.done}, 32'h0);
        check_eq("rst_fail", {31'h0, bus_a.fail}, 32'h0);
        check_eq("rst_s_wren", {31'h0, bus_a.s_wren}, 32'h0);
        check_eq("rst_dec_wren", {31'h0, bus_a.dec_wren}, 32'h0);
        check_eq("rst_s_addr", {24'h0, bus_a.s_address}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Identity S, zero ROM: keystream 02 05 07
        load_a(8'h00, 8'h00, 8'h00);
        run_a(1'b0, cyc, d1, b1);
        check_eq("t1_latency", cyc, 37);
        check_dec_a("t1", 8'h02, 8'h05, 8'h07);
        check_eq("t1_dec_cnt", dec_cnt_a, 3);
        check_eq("t1_S1", {24'h0, s_mem_a[1]}, 32'h01);
        check_eq("t1_S2", {24'h0, s_mem_a[2]}, 32'h03);
        check_eq("t1_S3", {24'h0, s_mem_a[3]}, 32'h05);
        check_eq("t1_S5", {24'h0, s_mem_a[5]}, 32'h02);
        check_eq("t1_busy", {31'h0, bus_a.busy}, 32'h0);
        check_eq("t1_fail", {31'h0, bus_a.fail}, 32'h0);

        // "aaa"
        load_a(8'h63, 8'h64, 8'h66);
        run_a(1'b0, cyc, d1, b1);
        check_eq("t2_latency", cyc, 37);
        check_dec_a("t2", 8'h61, 8'h61, 8'h61);
        check_eq("t2_fail", {31'h0, bus_a.fail}, 32'h0);

        // Non-letter second byte
        load_a(8'h63, 8'h00, 8'h66);
        run_a(1'b0, cyc, d1, b1);
`ifdef PRGA_ASCII_CHECK_EN
        check_eq("t3_latency", cyc, 25);
        check_dec_a("t3", 8'h61, 8'hEE, 8'hEE);
        check_eq("t3_dec_cnt", dec_cnt_a, 1);
        check_eq("t3_fail", {31'h0, bus_a.fail}, 32'h1);
`else
        check_eq("t3_latency", cyc, 37);
        check_dec_a("t3", 8'h61, 8'h05, 8'h61);
        check_eq("t3_dec_cnt", dec_cnt_a, 3);
        check_eq("t3_fail", {31'h0, bus_a.fail}, 32'h0);
`endif
        check_eq("t3_done", {31'h0, bus_a.done}, 32'h1);

        // Reset asserted during WR_J of byte 1 (write to S[3])
        load_a(8'h00, 8'h00, 8'h00);
        @(negedge clk);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (bus_a.s_wren && bus_a.s_address == 8'd3) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t4_wrj_seen", {31'h0, seen}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("t4_busy", {31'h0, bus_a.busy}, 32'h0);
        check_eq("t4_done", {31'h0, bus_a.done}, 32'h0);
        check_eq("t4_s_wren", {31'h0, bus_a.s_wren}, 32'h0);
        check_eq("t4_dec_wren", {31'h0, bus_a.dec_wren}, 32'h0);
        load_a(8'h00, 8'h00, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        run_a(1'b0, cyc, d1, b1);
        check_eq("t4_latency", cyc, 37);
        check_dec_a("t4", 8'h02, 8'h05, 8'h07);
        check_eq("t4_dec_cnt", dec_cnt_a, 3);

        // start pulses while busy are ignored
        load_a(8'h00, 8'h00, 8'h00);
        run_a(1'b1, cyc, d1, b1);
        check_eq("t5_latency", cyc, 37);
        check_dec_a("t5", 8'h02, 8'h05, 8'h07);
        check_eq("t5_dec_cnt", dec_cnt_a, 3);

        // start from DONE: done drops next cycle, second run completes
        load_a(8'h63, 8'h64, 8'h66);
        run_a(1'b0, cyc, d1, b1);
        check_eq("t6_done_drop", {31'h0, d1}, 32'h0);
        check_eq("t6_busy_rise", {31'h0, b1}, 32'h1);
        check_eq("t6_latency", cyc, 37);
        check_dec_a("t6", 8'h61, 8'h61, 8'h61);

        // 256-byte run, S[1]=FF so j=FF on byte 0; ROM = keystream ^ 'a'
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        ms[1] = 8'hFF;
        ms[255] = 8'h01;
        mi = 8'h00;
        mj = 8'h00;
        for (int n = 0; n < 256; n++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            tmp = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = tmp;
            tmp = ms[mi] + ms[mj];
            rom_b[n] = ms[tmp] ^ 8'h61;
        end
        @(negedge clk);
        s_init_b = 1'b1;
        @(negedge clk);
        s_init_b = 1'b0;
        bus_b.start = 1'b1;
        cyc = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            bus_b.start = 1'b0;
            if (bus_b.done) break;
        end
        check_eq("t7_latency", cyc, 12 * 256 + 1);
        check_eq("t7_wr_i_addr", {24'h0, swr0_b}, 32'h01);
        check_eq("t7_wr_j_addr", {24'h0, swr1_b}, 32'hFF);
        check_eq("t7_dec_cnt", dec_cnt_b, 256);
        check_eq("t7_dec_last", {24'h0, dec_last_b}, 32'hFF);
        bad = 0;
        for (int n = 0; n < 256; n++) if (dec_b[n] !== 8'h61) bad++;
        check_eq("t7_bad_bytes", bad, 0);
        check_eq("t7_fail", {31'h0, bus_b.fail}, 32'h0);
        check_eq("t7_done", {31'h0, bus_b.done}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
